// File: rtl/combo_dialer_pkg.sv
// Shared lock package: dialer FSM states, digit geometry, the lock's own state
// encodings and the factory combination.
package lock_pkg;

    localparam int NUM_DIGITS = 6;
    localparam int DIGIT_W    = 4;
    localparam int CODE_W     = NUM_DIGITS * DIGIT_W;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        CHECK,
        DONE
    } dial_state_t;

    // Encodings of the receiving lock's FSM (digits matched so far, then open/error).
    localparam logic [3:0] LOCK_S0   = 4'h0;
    localparam logic [3:0] LOCK_S1   = 4'h1;
    localparam logic [3:0] LOCK_S2   = 4'h2;
    localparam logic [3:0] LOCK_S3   = 4'h3;
    localparam logic [3:0] LOCK_S4   = 4'h4;
    localparam logic [3:0] LOCK_S5   = 4'h5;
    localparam logic [3:0] LOCK_OPEN = 4'h6;
    localparam logic [3:0] LOCK_ERR  = 4'hf;

    localparam logic [CODE_W-1:0] DEFAULT_COMBO = 24'h611371;

endpackage

// File: rtl/combo_dialer_if.sv
// Dialer bundle: host request/result signals plus the lock's digit-entry side.
interface combo_dialer_if #(
    parameter int NUM_DIGITS = lock_pkg::NUM_DIGITS,
    parameter int DIGIT_W    = lock_pkg::DIGIT_W
);
    logic                          start;
    logic [NUM_DIGITS*DIGIT_W-1:0] code;
    logic                          lock_open;
    logic [DIGIT_W-1:0]            digit_out;
    logic                          digit_valid;
    logic                          busy;
    logic                          done;
    logic                          opened;

    // master is the environment (host plus lock); slave is the dialer itself.
    modport master (
        output start, code, lock_open,
        input  digit_out, digit_valid, busy, done, opened
    );

    modport slave (
        input  start, code, lock_open,
        output digit_out, digit_valid, busy, done, opened
    );
endinterface

// File: rtl/combo_dialer_hold_timer.sv
// Loadable down-counter that times how long each digit sits on digit_out
// before its enter strobe.
module dial_hold_timer #(
    parameter int CNT_W       = 2,
    parameter int HOLD_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic expired
);
    logic [CNT_W-1:0] cnt;

    // Loaded with HOLD_CYCLES-1 so that expiry is seen on the last hold cycle.
    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= CNT_W'(HOLD_CYCLES - 1);
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign expired = (cnt == '0);
endmodule

// File: rtl/combo_dialer.sv
// Replays a packed six-digit combination into the lock's digit-entry port,
// one digit per enter strobe, then reports whether the lock opened.
module combo_dialer #(
    parameter int NUM_DIGITS  = lock_pkg::NUM_DIGITS,
    parameter int DIGIT_W     = lock_pkg::DIGIT_W,
    parameter int HOLD_CYCLES = 2
) (
    input logic            clk,
    input logic            rst_n,
    combo_dialer_if.slave  bus
);
    import lock_pkg::*;

    localparam int CODE_W = NUM_DIGITS * DIGIT_W;
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    dial_state_t        state;
    logic [CODE_W-1:0]  shreg;
    logic [IDX_W-1:0]   idx;
    logic [DIGIT_W-1:0] digit_q;
    logic               valid_q;
    logic               busy_q;
    logic               done_q;
    logic               opened_q;
    logic               hold_done;
    logic               timer_load;

    // The timer reloads outside SETUP, so each SETUP visit starts a fresh hold.
    assign timer_load = (state != SETUP);

    dial_hold_timer #(
        .CNT_W       (CNT_W),
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_hold_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (timer_load),
        .expired (hold_done)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            shreg    <= '0;
            idx      <= '0;
            digit_q  <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            opened_q <= 1'b0;
        end else begin
            // NOTE: one-cycle pulses default low here and are raised only
            // on the transition that owns them.
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        digit_q  <= bus.code[CODE_W-1 -: DIGIT_W];
                        shreg    <= bus.code << DIGIT_W;
                        idx      <= '0;
                        opened_q <= 1'b0;
                        busy_q   <= 1'b1;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    if (hold_done) begin
                        valid_q <= 1'b1;
                        state   <= STROBE;
                    end
                end
                STROBE: begin
                    if (idx == LAST_IDX) begin
                        state <= CHECK;
                    end else begin
                        idx     <= idx + 1'b1;
                        digit_q <= shreg[CODE_W-1 -: DIGIT_W];
                        shreg   <= shreg << DIGIT_W;
                        state   <= SETUP;
                    end
                end
                CHECK: begin
                    opened_q <= bus.lock_open;
                    done_q   <= 1'b1;
                    state    <= DONE;
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    digit_q <= '0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.digit_out   = digit_q;
    assign bus.digit_valid = valid_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.opened      = opened_q;
endmodule
